// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder: fills an 8-byte look-ahead, searches a 9-entry
// history one offset per cycle, and emits (code_pos, code_len, char_nxt) triples.
module lz77_encoder #(
  parameter int unsigned SEARCH_DEPTH = 9,
  parameter int unsigned LOOK_DEPTH   = 8,
  parameter logic [7:0]  TERM_CHAR    = 8'h24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] chardata,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [3:0] code_pos,
  output logic [2:0] code_len,
  output logic [7:0] char_nxt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       encode,
  output logic       finish
);

  typedef enum logic [2:0] {FILL, SEARCH, EMIT, SHIFT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              s_data [SEARCH_DEPTH];
  logic [SEARCH_DEPTH-1:0] s_vld;
  logic [7:0]              l_data [LOOK_DEPTH];
  logic [3:0]              lcnt;
  logic                    term_taken;
  logic [3:0]              p;
  logic [3:0]              best_pos;
  logic [2:0]              best_len;
  logic [2:0]              cand_len;
  logic [3:0]              shamt;
  logic [7:0]              nxt_byte;
  logic [7:0]              src;
  logic                    run;
  logic                    take;

  assign shamt    = {1'b0, best_len} + 4'd1;
  assign nxt_byte = l_data[best_len];

  // Match length at offset p; bytes past the search buffer come from the
  // look-ahead itself, which is what allows overlapping copies.
  always_comb begin
    cand_len = '0;
    src      = '0;
    run      = s_vld[p];
    for (int unsigned i = 0; i < LOOK_DEPTH - 1; i++) begin
      if (4'(i) <= p) src = s_data[p - 4'(i)];
      else            src = l_data[3'(4'(i) - p - 4'd1)];
      if (run && (4'(i) + 4'd1 < lcnt) && (src == l_data[3'(i)]) &&
          (l_data[3'(i)] != TERM_CHAR))
        cand_len = 3'(i + 1);
      else
        run = 1'b0;
    end
  end

  always_comb begin
    state_nxt  = state;
    char_ready = 1'b0;
    out_valid  = 1'b0;
    code_pos   = '0;
    code_len   = '0;
    char_nxt   = '0;
    finish     = 1'b0;
    take       = 1'b0;
    case (state)
      FILL: begin
        char_ready = encode && (lcnt < 4'(LOOK_DEPTH)) && !term_taken;
        take       = char_valid && char_ready;
        if (term_taken || (lcnt == 4'(LOOK_DEPTH)) ||
            (take && ((lcnt == 4'(LOOK_DEPTH - 1)) || (chardata == TERM_CHAR))))
          state_nxt = SEARCH;
      end
      SEARCH: if (p == 4'(SEARCH_DEPTH - 1)) state_nxt = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        code_pos  = best_pos;
        code_len  = best_len;
        char_nxt  = nxt_byte;
        if (out_ready) state_nxt = (nxt_byte == TERM_CHAR) ? DONE : SHIFT;
      end
      SHIFT:   state_nxt = FILL;
      DONE:    finish = 1'b1;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      s_vld      <= '0;
      lcnt       <= '0;
      term_taken <= 1'b0;
      p          <= '0;
      best_pos   <= '0;
      best_len   <= '0;
      encode     <= 1'b0;
    end else begin
      state  <= state_nxt;
      encode <= 1'b1;
      case (state)
        FILL: begin
          p        <= '0;
          best_pos <= '0;
          best_len <= '0;
          if (take) begin
            l_data[lcnt[2:0]] <= chardata;
            lcnt              <= lcnt + 4'd1;
            if (chardata == TERM_CHAR) term_taken <= 1'b1;
          end
        end
        SEARCH: begin
          if (cand_len > best_len) begin
            best_len <= cand_len;
            best_pos <= p;
          end
          p <= p + 4'd1;
        end
        SHIFT: begin
          // Consumed look-ahead bytes enter the history newest-first.
          for (int unsigned j = 0; j < SEARCH_DEPTH; j++) begin
            if (4'(j) < shamt) begin
              s_data[j] <= l_data[3'(shamt - 4'd1 - 4'(j))];
              s_vld[j]  <= 1'b1;
            end else begin
              s_data[j] <= s_data[4'(j) - shamt];
              s_vld[j]  <= s_vld[4'(j) - shamt];
            end
          end
          for (int unsigned j = 0; j < LOOK_DEPTH; j++) begin
            if (4'(j) + shamt < 4'(LOOK_DEPTH)) l_data[j] <= l_data[3'(4'(j) + shamt)];
          end
          lcnt <= lcnt - shamt;
        end
        default: ;
      endcase
    end
  end

endmodule
